// File: rtl/hazard_fwd_scoreboard.sv
// rtl/hazard_fwd_scoreboard.sv - in-flight writer scoreboard driving decode stall and operand forwarding selects
module hazard_fwd_scoreboard #(
    parameter int NUM_SRC   = 2,
    parameter int STAGES    = 3,
    parameter int REG_IDX_W = 5,
    parameter int SELW      = $clog2(STAGES + 1),
    parameter int RSW       = $clog2(STAGES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid_i,
    input  logic [NUM_SRC*REG_IDX_W-1:0] id_src_idx_i,
    input  logic [NUM_SRC-1:0]           id_src_used_i,
    input  logic                         id_reg_wr_i,
    input  logic [REG_IDX_W-1:0]         id_dest_idx_i,
    input  logic [RSW-1:0]               id_ready_stage_i,
    input  logic                         flush_i,
    input  logic                         hold_i,
    output logic                         stall_o,
    output logic [NUM_SRC*SELW-1:0]      fwd_sel_o,
    output logic [SELW-1:0]              inflight_o,
    output logic [31:0]                  stall_cycles_o
);

    logic [STAGES-1:0]    valid_q;
    logic [REG_IDX_W-1:0] dest_q  [STAGES];
    logic [RSW-1:0]       ready_q [STAGES];

    logic                 hazard;
    logic                 insert;
    logic [REG_IDX_W-1:0] src;
    logic                 hit;
    int                   hit_s;

    // Scan oldest to youngest so the youngest matching writer is the one left standing.
    always_comb begin
        fwd_sel_o = '0;
        hazard    = 1'b0;
        src       = '0;
        hit       = 1'b0;
        hit_s     = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            src   = id_src_idx_i[k*REG_IDX_W +: REG_IDX_W];
            hit   = 1'b0;
            hit_s = 0;
            for (int s = STAGES - 1; s >= 0; s--) begin
                if (valid_q[s] && dest_q[s] == src) begin
                    hit   = 1'b1;
                    hit_s = s;
                end
            end
            if (id_src_used_i[k] && src != '0 && hit) begin
                if (hit_s >= int'(ready_q[hit_s]))
                    fwd_sel_o[k*SELW +: SELW] = SELW'(hit_s + 1);
                else
                    hazard = 1'b1;
            end
        end
    end

    assign stall_o = id_valid_i & ~flush_i & (hold_i | hazard);
    assign insert  = id_valid_i & id_reg_wr_i & (id_dest_idx_i != '0) & ~flush_i & ~stall_o;

    always_comb begin
        inflight_o = '0;
        for (int s = 0; s < STAGES; s++)
            inflight_o = inflight_o + SELW'(valid_q[s]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q        <= '0;
            stall_cycles_o <= '0;
            for (int s = 0; s < STAGES; s++) begin
                dest_q[s]  <= '0;
                ready_q[s] <= '0;
            end
        end else if (!hold_i) begin
            for (int s = 1; s < STAGES; s++) begin
                valid_q[s] <= valid_q[s-1];
                dest_q[s]  <= dest_q[s-1];
                ready_q[s] <= ready_q[s-1];
            end
            valid_q[0] <= insert;
            dest_q[0]  <= id_dest_idx_i;
            ready_q[0] <= id_ready_stage_i;
            if (stall_o && stall_cycles_o != 32'hFFFF_FFFF)
                stall_cycles_o <= stall_cycles_o + 32'd1;
        end
    end

    a_ready_stage_legal: assert property (@(posedge clk) disable iff (rst)
        (id_valid_i && id_reg_wr_i) |-> (int'(id_ready_stage_i) < STAGES));

endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// tb/tb_hazard_fwd_scoreboard.sv - directed and random checks of hazard_fwd_scoreboard against a writer-list model
module tb_hazard_fwd_scoreboard;
    localparam int NS = 2;
    localparam int ST = 4;
    localparam int RW = 5;
    localparam int SW = $clog2(ST + 1);
    localparam int RS = $clog2(ST);

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [NS*RW-1:0]  id_src_idx;
    logic [NS-1:0]     id_src_used;
    logic              id_reg_wr;
    logic [RW-1:0]     id_dest_idx;
    logic [RS-1:0]     id_ready_stage;
    logic              flush;
    logic              hold;
    logic              stall;
    logic [NS*SW-1:0]  fwd_sel;
    logic [SW-1:0]     inflight;
    logic [31:0]       stall_cycles;

    hazard_fwd_scoreboard #(.NUM_SRC(NS), .STAGES(ST), .REG_IDX_W(RW)) dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid), .id_src_idx_i(id_src_idx), .id_src_used_i(id_src_used),
        .id_reg_wr_i(id_reg_wr), .id_dest_idx_i(id_dest_idx), .id_ready_stage_i(id_ready_stage),
        .flush_i(flush), .hold_i(hold),
        .stall_o(stall), .fwd_sel_o(fwd_sel), .inflight_o(inflight), .stall_cycles_o(stall_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: list of in-flight writers, each tagged with how many cycles it has advanced past ID.
    int     m_dest[$];
    int     m_rdy[$];
    int     m_stg[$];
    longint m_cnt;
    bit     m_stall, m_ins, m_hold;
    int     m_d, m_r;

    task automatic model_clear();
        m_dest.delete(); m_rdy.delete(); m_stg.delete();
        m_cnt = 0;
    endtask

    task automatic apply(input bit v, input int s0, input int s1, input bit [1:0] used,
                         input bit wr, input int d, input int r, input bit fl, input bit hd);
        int  idx, best, sel;
        bit  hz;
        id_valid       = v;
        id_src_idx     = {RW'(s1), RW'(s0)};
        id_src_used    = used;
        id_reg_wr      = wr;
        id_dest_idx    = RW'(d);
        id_ready_stage = RS'(r);
        flush          = fl;
        hold           = hd;
        @(negedge clk);
        hz = 0;
        for (int k = 0; k < NS; k++) begin
            idx = (k == 0) ? s0 : s1;
            sel = 0;
            if (used[k] && idx != 0) begin
                best = -1;
                foreach (m_dest[i])
                    if (m_dest[i] == idx && (best < 0 || m_stg[i] < m_stg[best])) best = i;
                if (best >= 0) begin
                    if (m_stg[best] >= m_rdy[best]) sel = m_stg[best] + 1;
                    else hz = 1;
                end
            end
            check($sformatf("fwd_sel[%0d]", k), fwd_sel[k*SW +: SW], sel);
        end
        m_stall = v && !fl && (hd || hz);
        m_ins   = v && wr && d != 0 && !fl && !m_stall;
        m_hold  = hd;
        m_d     = d;
        m_r     = r;
        check("stall", stall, m_stall);
        check("inflight", inflight, m_dest.size());
        check("stall_cycles", stall_cycles, m_cnt);
    endtask

    task automatic advance();
        if (!m_hold) begin
            for (int i = m_dest.size() - 1; i >= 0; i--) begin
                m_stg[i]++;
                if (m_stg[i] >= ST) begin
                    m_dest.delete(i); m_rdy.delete(i); m_stg.delete(i);
                end
            end
            if (m_ins) begin
                m_dest.push_back(m_d); m_rdy.push_back(m_r); m_stg.push_back(0);
            end
            if (m_stall && m_cnt != 64'hFFFF_FFFF) m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit v, input int s0, input int s1, input bit [1:0] used,
                        input bit wr, input int d, input int r, input bit fl, input bit hd);
        apply(v, s0, s1, used, wr, d, r, fl, hd);
        advance();
    endtask

    task automatic do_reset();
        id_valid = 0; id_src_idx = '0; id_src_used = '0; id_reg_wr = 0;
        id_dest_idx = '0; id_ready_stage = '0; flush = 0; hold = 0;
        rst = 1;
        model_clear();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        do_reset();
        rst = 1;
        #2;
        check("reset_stall", stall, 0);
        check("reset_fwd_sel", fwd_sel, 0);
        check("reset_inflight", inflight, 0);
        check("reset_cnt", stall_cycles, 0);
        rst = 0;

        // ALU back-to-back
        step(1, 0, 0, 2'b00, 1, 5, 0, 0, 0);
        apply(1, 5, 5, 2'b11, 1, 6, 0, 0, 0);
        check("alu_stall", stall, 0);
        check("alu_sel", fwd_sel, {3'd1, 3'd1});
        advance();

        // Load-use
        do_reset();
        step(1, 0, 0, 2'b00, 1, 7, 1, 0, 0);
        apply(1, 7, 0, 2'b11, 1, 8, 0, 0, 0);
        check("lu_stall", stall, 1);
        advance();
        apply(1, 7, 0, 2'b11, 1, 8, 0, 0, 0);
        check("lu_stall_done", stall, 0);
        check("lu_sel", fwd_sel[SW-1:0], 2);
        check("lu_cnt", stall_cycles, 1);
        advance();

        // Multi-cycle writer ready in WB
        do_reset();
        step(1, 0, 0, 2'b00, 1, 9, 3, 0, 0);
        for (int c = 0; c < 3; c++) begin
            apply(1, 0, 9, 2'b10, 1, 10, 0, 0, 0);
            check("mul_stall", stall, 1);
            advance();
        end
        apply(1, 0, 9, 2'b10, 1, 10, 0, 0, 0);
        check("mul_stall_done", stall, 0);
        check("mul_sel", fwd_sel[SW +: SW], 4);
        check("mul_cnt", stall_cycles, 3);
        advance();

        // Youngest wins, x0 and unused sources
        do_reset();
        step(1, 0, 0, 2'b00, 1, 3, 0, 0, 0);
        step(1, 0, 0, 2'b00, 1, 3, 0, 0, 0);
        step(1, 0, 0, 2'b00, 1, 0, 0, 0, 0);
        apply(1, 3, 3, 2'b01, 1, 4, 0, 0, 0);
        check("young_sel0", fwd_sel[SW-1:0], 2);
        check("unused_sel1", fwd_sel[SW +: SW], 0);
        advance();
        apply(1, 0, 0, 2'b11, 0, 0, 0, 0, 0);
        check("x0_stall", stall, 0);
        check("x0_sel", fwd_sel, 0);
        advance();

        // Flush and hold
        do_reset();
        step(1, 0, 0, 2'b00, 1, 10, 2, 1, 0);
        apply(1, 10, 0, 2'b01, 0, 0, 0, 0, 0);
        check("flush_inflight", inflight, 0);
        check("flush_stall", stall, 0);
        advance();
        step(1, 0, 0, 2'b00, 1, 11, 2, 0, 0);
        for (int c = 0; c < 5; c++) begin
            apply(1, 11, 0, 2'b01, 0, 0, 0, 0, 1);
            check("hold_stall", stall, 1);
            check("hold_inflight", inflight, 1);
            check("hold_cnt", stall_cycles, 0);
            advance();
        end

        // Asynchronous reset in the middle of a stall
        do_reset();
        step(1, 0, 0, 2'b00, 1, 7, 1, 0, 0);
        apply(1, 7, 0, 2'b01, 0, 0, 0, 0, 0);
        check("ar_pre_stall", stall, 1);
        rst = 1;
        #1;
        check("ar_stall", stall, 0);
        check("ar_inflight", inflight, 0);
        check("ar_cnt", stall_cycles, 0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 0;

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 3) != 0),
                 $urandom_range(0, 4), $urandom_range(0, 4),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 4), $urandom_range(0, ST - 1),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
